pipe_hazard_ctrl: RTL and testbench

//  Parametrised Y86 pipeline control unit, successor to the combinational stall/bubble logic.

---
 rtl/pipe_hazard_ctrl_if.sv | 51 +++++
 rtl/pipe_hazard_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle of pipeline-side signals between the stage registers and pipe_hazard_ctrl.
//  master : pipeline side (drives stage fields, dmem handshake and cnt_clr; receives controls)
//  slave  : hazard controller (receives stage fields; drives stall/bubble/cc, status and counters)
interface pipe_hazard_ctrl_if #(
  parameter int unsigned ICODE_W = 4,
  parameter int unsigned REG_W   = 4,
  parameter int unsigned STAT_W  = 3,
  parameter int unsigned CNT_W   = 16
);
  // stage fields and handshake
  logic [ICODE_W-1:0] D_icode;
  logic [REG_W-1:0]   d_srcA;
  logic [REG_W-1:0]   d_srcB;
  logic [ICODE_W-1:0] E_icode;
  logic [REG_W-1:0]   E_dstM;
  logic               e_cnd;
  logic [ICODE_W-1:0] M_icode;
  logic [STAT_W-1:0]  m_stat;
  logic [STAT_W-1:0]  W_stat;
  logic               dmem_req;
  logic               dmem_ready;
  logic               cnt_clr;

  // pipeline controls
  logic F_stall, D_stall, E_stall, M_stall, W_stall;
  logic D_bubble, E_bubble, M_bubble, W_bubble;
  logic set_cc;

  // status and counters
  logic             halted;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] bubble_cycles;
  logic [CNT_W-1:0] mispredicts;

  modport master (
    output D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_cnd, M_icode,
           m_stat, W_stat, dmem_req, dmem_ready, cnt_clr,
    input  F_stall, D_stall, E_stall, M_stall, W_stall,
           D_bubble, E_bubble, M_bubble, W_bubble, set_cc,
           halted, mem_timeout, stall_cycles, bubble_cycles, mispredicts
  );

  modport slave (
    input  D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_cnd, M_icode,
           m_stat, W_stat, dmem_req, dmem_ready, cnt_clr,
    output F_stall, D_stall, E_stall, M_stall, W_stall,
           D_bubble, E_bubble, M_bubble, W_bubble, set_cc,
           halted, mem_timeout, stall_cycles, bubble_cycles, mispredicts
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Y86 pipeline hazard control unit.
// Detects load/use, ret, mispredict and exception hazards and drives per-stage
// stall/bubble controls plus the CC write enable. A data-memory wait freezes
// F..M; a wait that runs too long or a write-back exception parks the unit in
// a sticky HALT state that only reset leaves. Saturating counters track stall,
// bubble and mispredict activity.
// Ports:
//  clk, rst : clock, asynchronous active-high reset
//  bus      : pipe_hazard_ctrl_if.slave (stage fields in; controls, status, counters out)
// Pipeline controls are combinational from the current inputs and state.
module pipe_hazard_ctrl #(
  parameter int unsigned       ICODE_W  = 4,
  parameter int unsigned       REG_W    = 4,
  parameter int unsigned       STAT_W   = 3,
  parameter logic [REG_W-1:0]  RNONE    = REG_W'(4'hF),
  parameter int unsigned       WAIT_MAX = 16,
  parameter int unsigned       CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  pipe_hazard_ctrl_if.slave bus
);

  localparam int unsigned WCNT_W = (WAIT_MAX > 2) ? $clog2(WAIT_MAX) : 1;

  localparam logic [STAT_W-1:0]  S_HLT = STAT_W'(2);
  localparam logic [STAT_W-1:0]  S_ADR = STAT_W'(3);
  localparam logic [STAT_W-1:0]  S_INS = STAT_W'(4);

  localparam logic [ICODE_W-1:0] I_OPL    = ICODE_W'(6);
  localparam logic [ICODE_W-1:0] I_JXX    = ICODE_W'(7);
  localparam logic [ICODE_W-1:0] I_MRMOVL = ICODE_W'(5);
  localparam logic [ICODE_W-1:0] I_RET    = ICODE_W'(9);
  localparam logic [ICODE_W-1:0] I_POPL   = ICODE_W'(11);

  localparam logic [WCNT_W-1:0]  WCNT_LAST = WCNT_W'(WAIT_MAX - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX   = '1;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MEMWAIT = 2'd1,
    ST_HALT    = 2'd2
  } state_t;

  function automatic logic is_exc(input logic [STAT_W-1:0] s);
    return (s == S_HLT) || (s == S_ADR) || (s == S_INS);
  endfunction

  // Hazard predicates
  logic exc_m, exc_w, lu, ret, misp, wt;

  always_comb begin
    exc_m = is_exc(bus.m_stat);
    exc_w = is_exc(bus.W_stat);
    lu    = ((bus.E_icode == I_MRMOVL) || (bus.E_icode == I_POPL)) &&
            (bus.E_dstM != RNONE) &&
            ((bus.E_dstM == bus.d_srcA) || (bus.E_dstM == bus.d_srcB));
    ret   = (bus.D_icode == I_RET) || (bus.E_icode == I_RET) || (bus.M_icode == I_RET);
    misp  = (bus.E_icode == I_JXX) && !bus.e_cnd;
    wt    = bus.dmem_req && !bus.dmem_ready && !exc_m;
  end

  // FSM state register, wait counter and sticky timeout flag
  state_t            state, state_nxt;
  logic [WCNT_W-1:0] wcnt, wcnt_nxt;
  logic              timeout_set;
  logic              mem_timeout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_RUN;
      wcnt        <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
      if (timeout_set) mem_timeout <= 1'b1;
    end
  end

  // Next-state logic; a write-back exception overrides any wait progress
  always_comb begin
    state_nxt   = state;
    wcnt_nxt    = wcnt;
    timeout_set = 1'b0;
    case (state)
      ST_RUN: begin
        if (wt) begin
          state_nxt = ST_MEMWAIT;
          wcnt_nxt  = WCNT_W'(1);
        end
      end
      ST_MEMWAIT: begin
        if (!wt) begin
          state_nxt = ST_RUN;
        end else if (wcnt == WCNT_LAST) begin
          state_nxt   = ST_HALT;
          timeout_set = 1'b1;
        end else begin
          wcnt_nxt = wcnt + WCNT_W'(1);
        end
      end
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_RUN;
    endcase
    if (exc_w) state_nxt = ST_HALT;
  end

  // Output logic: HALT > memory wait > normal hazard handling
  logic halt_c;
  logic f_stall, d_stall, e_stall, m_stall, w_stall;
  logic d_bubble, e_bubble, m_bubble, w_bubble, set_cc;

  always_comb begin
    halt_c   = (state == ST_HALT);
    f_stall  = 1'b0;
    d_stall  = 1'b0;
    e_stall  = 1'b0;
    m_stall  = 1'b0;
    w_stall  = 1'b0;
    d_bubble = 1'b0;
    e_bubble = 1'b0;
    m_bubble = 1'b0;
    w_bubble = 1'b0;
    set_cc   = 1'b0;
    if (halt_c) begin
      f_stall  = 1'b1;
      d_stall  = 1'b1;
      e_stall  = 1'b1;
      m_stall  = 1'b1;
      w_stall  = 1'b1;
      m_bubble = 1'b1;
    end else if (wt) begin
      f_stall  = 1'b1;
      d_stall  = 1'b1;
      e_stall  = 1'b1;
      m_stall  = 1'b1;
      w_bubble = 1'b1;
    end else begin
      f_stall  = lu || ret;
      d_stall  = lu;
      // a load/use stall on D takes precedence over the ret bubble
      d_bubble = misp || (!lu && ret);
      e_bubble = misp || lu;
      m_bubble = exc_m || exc_w;
      w_stall  = exc_w;
      set_cc   = (bus.E_icode == I_OPL) && !exc_m && !exc_w;
    end
  end

  assign bus.F_stall     = f_stall;
  assign bus.D_stall     = d_stall;
  assign bus.E_stall     = e_stall;
  assign bus.M_stall     = m_stall;
  assign bus.W_stall     = w_stall;
  assign bus.D_bubble    = d_bubble;
  assign bus.E_bubble    = e_bubble;
  assign bus.M_bubble    = m_bubble;
  assign bus.W_bubble    = w_bubble;
  assign bus.set_cc      = set_cc;
  assign bus.halted      = halt_c;
  assign bus.mem_timeout = mem_timeout;

  // Performance counters; a jump held by a wait is only counted once it moves on
  logic             stall_inc, bubble_inc, misp_inc;
  logic [CNT_W-1:0] stall_cnt, bubble_cnt, misp_cnt;

  always_comb begin
    stall_inc  = !halt_c && (wt || lu);
    bubble_inc = d_bubble || e_bubble;
    misp_inc   = !halt_c && !wt && misp;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
      misp_cnt   <= '0;
    end else if (bus.cnt_clr) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
      misp_cnt   <= '0;
    end else begin
      if (stall_inc  && (stall_cnt  != CNT_MAX)) stall_cnt  <= stall_cnt  + CNT_W'(1);
      if (bubble_inc && (bubble_cnt != CNT_MAX)) bubble_cnt <= bubble_cnt + CNT_W'(1);
      if (misp_inc   && (misp_cnt   != CNT_MAX)) misp_cnt   <= misp_cnt   + CNT_W'(1);
    end
  end

  assign bus.stall_cycles  = stall_cnt;
  assign bus.bubble_cycles = bubble_cnt;
  assign bus.mispredicts   = misp_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: combinational vector table plus multi-cycle sequences.
module tb_pipe_hazard_ctrl;

  localparam int unsigned CNT_W    = 4;
  localparam int unsigned WAIT_MAX = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipe_hazard_ctrl #(.CNT_W(CNT_W), .WAIT_MAX(WAIT_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // {F,D,E,M,W stall, D,E,M,W bubble, set_cc}
  logic [9:0] outs;
  assign outs = {bus.F_stall, bus.D_stall, bus.E_stall, bus.M_stall, bus.W_stall,
                 bus.D_bubble, bus.E_bubble, bus.M_bubble, bus.W_bubble, bus.set_cc};

  localparam logic [9:0] O_NONE = 10'b00000_0000_0;
  localparam logic [9:0] O_HALT = 10'b11111_0010_0;
  localparam logic [9:0] O_WAIT = 10'b11110_0001_0;

  typedef struct {
    string      name;
    logic [3:0] d_icode, d_srca, d_srcb, e_icode, e_dstm;
    logic       e_cnd;
    logic [3:0] m_icode;
    logic [2:0] m_stat, w_stat;
    logic       req, rdy;
    logic [9:0] exp;
  } vec_t;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic idle();
    bus.D_icode = 4'h1; bus.d_srcA = 4'hF; bus.d_srcB = 4'hF;
    bus.E_icode = 4'h1; bus.E_dstM = 4'hF; bus.e_cnd = 1'b0;
    bus.M_icode = 4'h1; bus.m_stat = 3'd1; bus.W_stat = 3'd1;
    bus.dmem_req = 1'b0; bus.dmem_ready = 1'b0; bus.cnt_clr = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    bus.D_icode = v.d_icode; bus.d_srcA = v.d_srca; bus.d_srcB = v.d_srcb;
    bus.E_icode = v.e_icode; bus.E_dstM = v.e_dstm; bus.e_cnd = v.e_cnd;
    bus.M_icode = v.m_icode; bus.m_stat = v.m_stat; bus.W_stat = v.w_stat;
    bus.dmem_req = v.req; bus.dmem_ready = v.rdy;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle();
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  vec_t vecs[$];

  initial begin
    //             name        D  sA sB E  dM c  M  ms ws rq rd exp
    vecs.push_back('{"lu_srcA",  1, 3, 15, 5, 3, 0, 1, 1, 1, 0, 0, 10'b11000_0100_0});
    vecs.push_back('{"lu_rnone", 1, 3, 15, 5, 15,0, 1, 1, 1, 0, 0, O_NONE});
    vecs.push_back('{"misp",     1, 15,15, 7, 15,0, 1, 1, 1, 0, 0, 10'b00000_1100_0});
    vecs.push_back('{"jmp_ok",   1, 15,15, 7, 15,1, 1, 1, 1, 0, 0, O_NONE});
    vecs.push_back('{"lu_ret",   9, 15, 2, 5, 2, 0, 1, 1, 1, 0, 0, 10'b11000_0100_0});
    vecs.push_back('{"ret_D",    9, 15,15, 1, 15,0, 1, 1, 1, 0, 0, 10'b10000_1000_0});
    vecs.push_back('{"ret_M",    1, 15,15, 1, 15,0, 9, 1, 1, 0, 0, 10'b10000_1000_0});
    vecs.push_back('{"lu_popl",  1, 15, 4, 11,4, 0, 1, 1, 1, 0, 0, 10'b11000_0100_0});
    vecs.push_back('{"opl_cc",   1, 15,15, 6, 15,0, 1, 1, 1, 0, 0, 10'b00000_0000_1});
    vecs.push_back('{"opl_madr", 1, 15,15, 6, 15,0, 1, 3, 1, 0, 0, 10'b00000_0010_0});
    vecs.push_back('{"opl_wins", 1, 15,15, 6, 15,0, 1, 1, 4, 0, 0, 10'b00001_0010_0});
    vecs.push_back('{"wait",     1, 15,15, 1, 15,0, 1, 1, 1, 1, 0, O_WAIT});
    vecs.push_back('{"wait_lu",  1, 3, 15, 5, 3, 0, 1, 1, 1, 1, 0, O_WAIT});
    vecs.push_back('{"wait_exc", 1, 15,15, 1, 15,0, 1, 3, 1, 1, 0, 10'b00000_0010_0});
    vecs.push_back('{"req_rdy",  1, 15,15, 1, 15,0, 1, 1, 1, 1, 1, O_NONE});
    vecs.push_back('{"misp_ret", 1, 15,15, 7, 15,0, 9, 1, 1, 0, 0, 10'b10000_1100_0});
    vecs.push_back('{"m_hlt",    1, 15,15, 1, 15,0, 1, 2, 1, 0, 0, 10'b00000_0010_0});
    vecs.push_back('{"rmmov_nl", 1, 3, 15, 4, 3, 0, 1, 1, 1, 0, 0, O_NONE});

    idle();
    do_reset();

    // reset state
    chk("rst_outs", 32'(outs), 32'(O_NONE));
    chk("rst_halted", 32'(bus.halted), 32'd0);
    chk("rst_timeout", 32'(bus.mem_timeout), 32'd0);
    chk("rst_stallcnt", 32'(bus.stall_cycles), 32'd0);
    chk("rst_bubcnt", 32'(bus.bubble_cycles), 32'd0);
    chk("rst_mispcnt", 32'(bus.mispredicts), 32'd0);

    // combinational vectors, returned to idle before each clock edge
    foreach (vecs[i]) begin
      @(negedge clk);
      apply(vecs[i]);
      #1;
      chk(vecs[i].name, 32'(outs), 32'(vecs[i].exp));
      #1;
      idle();
    end
    chk("vec_no_halt", 32'(bus.halted), 32'd0);

    // mispredict counted once per edge
    do_reset();
    @(negedge clk);
    bus.E_icode = 4'h7; bus.e_cnd = 1'b0;
    @(negedge clk);
    idle();
    chk("misp_cnt", 32'(bus.mispredicts), 32'd1);
    chk("misp_bubcnt", 32'(bus.bubble_cycles), 32'd1);

    // held jump during a wait is counted only when it proceeds
    do_reset();
    @(negedge clk);
    bus.E_icode = 4'h7; bus.e_cnd = 1'b0; bus.dmem_req = 1'b1; bus.dmem_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("held_misp0", 32'(bus.mispredicts), 32'd0);
    bus.dmem_ready = 1'b1;
    @(negedge clk);
    idle();
    chk("held_misp1", 32'(bus.mispredicts), 32'd1);

    // three-cycle memory wait then completion
    do_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      bus.dmem_req = 1'b1; bus.dmem_ready = 1'b0;
      #1;
      chk($sformatf("wait3_c%0d", c), 32'(outs), 32'(O_WAIT));
    end
    @(negedge clk);
    bus.dmem_ready = 1'b1;
    #1;
    chk("wait3_done", 32'(outs), 32'(O_NONE));
    @(negedge clk);
    idle();
    chk("wait3_stallcnt", 32'(bus.stall_cycles), 32'd3);
    chk("wait3_halted", 32'(bus.halted), 32'd0);

    // wait timeout into HALT, then reset
    do_reset();
    @(negedge clk);
    bus.dmem_req = 1'b1; bus.dmem_ready = 1'b0;
    repeat (WAIT_MAX - 1) @(negedge clk);
    chk("to_not_yet", 32'(bus.halted), 32'd0);
    @(negedge clk);
    idle();
    #1;
    chk("to_halted", 32'(bus.halted), 32'd1);
    chk("to_flag", 32'(bus.mem_timeout), 32'd1);
    chk("to_outs", 32'(outs), 32'(O_HALT));
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("to_rst_halted", 32'(bus.halted), 32'd0);
    chk("to_rst_flag", 32'(bus.mem_timeout), 32'd0);
    chk("to_rst_outs", 32'(outs), 32'(O_NONE));
    @(negedge clk);
    rst = 1'b0;

    // m_stat exception blocks set_cc, W_stat exception halts stickily
    do_reset();
    @(negedge clk);
    bus.E_icode = 4'h6; bus.m_stat = 3'd3;
    #1;
    chk("exc_cc", 32'(bus.set_cc), 32'd0);
    chk("exc_mbub", 32'(bus.M_bubble), 32'd1);
    @(negedge clk);
    chk("exc_no_halt", 32'(bus.halted), 32'd0);
    bus.W_stat = 3'd2;
    @(negedge clk);
    idle();
    #1;
    chk("exc_halted", 32'(bus.halted), 32'd1);
    chk("exc_no_tflag", 32'(bus.mem_timeout), 32'd0);
    repeat (2) @(negedge clk);
    bus.E_icode = 4'h5; bus.E_dstM = 4'h3; bus.d_srcA = 4'h3;
    #1;
    chk("exc_sticky", 32'(bus.halted), 32'd1);
    chk("exc_outs", 32'(outs), 32'(O_HALT));
    @(negedge clk);
    idle();
    chk("halt_no_stallcnt", 32'(bus.stall_cycles), 32'd0);

    // counter saturation and clear
    do_reset();
    @(negedge clk);
    bus.D_icode = 4'h9;
    repeat (20) @(negedge clk);
    chk("sat_bubcnt", 32'(bus.bubble_cycles), 32'd15);
    chk("sat_stallcnt", 32'(bus.stall_cycles), 32'd0);
    bus.cnt_clr = 1'b1;
    @(negedge clk);
    bus.cnt_clr = 1'b0;
    idle();
    chk("clr_bubcnt", 32'(bus.bubble_cycles), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
